// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Parametrised VGA raster timing generator. Produces hsync/vsync,
//             the video-on window, raw counters, active-area coordinates and
//             line/frame start strobes. All outputs pass through a LAT-deep
//             pipeline so they line up with downstream pixel generation.
//  Ports    : clk         - system clock
//             clr         - synchronous active-high reset (overrides pix_en)
//             pix_en      - pixel strobe; counters and pipeline advance on it
//             hsync/vsync - sync outputs, active level set by HS_POL/VS_POL
//             vidon       - high inside the active area
//             hc/vc       - raw counters, delayed by LAT pixel strobes
//             px/py       - active-area coordinates, 0 outside active area
//             line_start  - one-clk strobe for hc==0
//             frame_start - one-clk strobe for hc==0 && vc==0
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
   parameter int H_ACTIVE = 1024,
   parameter int H_FP     = 24,
   parameter int H_SYNC   = 136,
   parameter int H_BP     = 160,
   parameter int V_ACTIVE = 768,
   parameter int V_FP     = 3,
   parameter int V_SYNC   = 6,
   parameter int V_BP     = 29,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CW       = 11,
   parameter int LAT      = 1
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          pix_en,
   output logic          hsync,
   output logic          vsync,
   output logic          vidon,
   output logic [CW-1:0] hc,
   output logic [CW-1:0] vc,
   output logic [CW-1:0] px,
   output logic [CW-1:0] py,
   output logic          line_start,
   output logic          frame_start
);

   localparam int c_h_total = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int c_v_total = V_SYNC + V_BP + V_ACTIVE + V_FP;

   localparam logic [CW-1:0] c_h_last = CW'(c_h_total - 1);
   localparam logic [CW-1:0] c_v_last = CW'(c_v_total - 1);
   localparam logic [CW-1:0] c_h_sync = CW'(H_SYNC);
   localparam logic [CW-1:0] c_v_sync = CW'(V_SYNC);
   localparam logic [CW-1:0] c_h_act0 = CW'(H_SYNC + H_BP);
   localparam logic [CW-1:0] c_h_act1 = CW'(H_SYNC + H_BP + H_ACTIVE - 1);
   localparam logic [CW-1:0] c_v_act0 = CW'(V_SYNC + V_BP);
   localparam logic [CW-1:0] c_v_act1 = CW'(V_SYNC + V_BP + V_ACTIVE - 1);

   // One pipeline stage carries the full decode of one counter value.
   // Sync is carried as "active" and converted to pin polarity at the output.
   typedef struct packed {
      logic          hs;
      logic          vs;
      logic          act;
      logic [CW-1:0] hc;
      logic [CW-1:0] vc;
      logic [CW-1:0] px;
      logic [CW-1:0] py;
      logic          ls;
      logic          fs;
   } stage_t;

   localparam stage_t c_idle = '0;

   logic [CW-1:0] r_hc;
   logic [CW-1:0] r_vc;
   stage_t        w_dec;
   logic          w_h_in;
   logic          w_v_in;
   stage_t        r_pipe [LAT];

   // Stage-0 raster counters
   always_ff @(posedge clk) begin
      if (clr) begin
         r_hc <= '0;
         r_vc <= '0;
      end else if (pix_en) begin
         if (r_hc == c_h_last) begin
            r_hc <= '0;
            r_vc <= (r_vc == c_v_last) ? '0 : r_vc + CW'(1);
         end else begin
            r_hc <= r_hc + CW'(1);
         end
      end
   end

   // Decode of the current counter value
   always_comb begin
      w_dec     = c_idle;
      w_h_in    = (r_hc >= c_h_act0) && (r_hc <= c_h_act1);
      w_v_in    = (r_vc >= c_v_act0) && (r_vc <= c_v_act1);
      w_dec.hs  = (r_hc < c_h_sync);
      w_dec.vs  = (r_vc < c_v_sync);
      w_dec.act = w_h_in && w_v_in;
      w_dec.hc  = r_hc;
      w_dec.vc  = r_vc;
      if (w_h_in && w_v_in) begin
         w_dec.px = r_hc - c_h_act0;
         w_dec.py = r_vc - c_v_act0;
      end
      w_dec.ls  = (r_hc == '0);
      w_dec.fs  = (r_hc == '0) && (r_vc == '0);
   end

   // Output pipeline. The final stage's strobe bits are cleared on any cycle
   // without pix_en so they stay one clk wide; earlier stages keep theirs so
   // the strobe still propagates on the next pix_en.
   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < LAT; i++) begin
            r_pipe[i] <= c_idle;
         end
      end else if (pix_en) begin
         r_pipe[0] <= w_dec;
         for (int i = 1; i < LAT; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
      end else begin
         r_pipe[LAT-1].ls <= 1'b0;
         r_pipe[LAT-1].fs <= 1'b0;
      end
   end

   assign hsync       = r_pipe[LAT-1].hs ? HS_POL : ~HS_POL;
   assign vsync       = r_pipe[LAT-1].vs ? VS_POL : ~VS_POL;
   assign vidon       = r_pipe[LAT-1].act;
   assign hc          = r_pipe[LAT-1].hc;
   assign vc          = r_pipe[LAT-1].vc;
   assign px          = r_pipe[LAT-1].px;
   assign py          = r_pipe[LAT-1].py;
   assign line_start  = r_pipe[LAT-1].ls;
   assign frame_start = r_pipe[LAT-1].fs;

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 1024x768 VGA controller.
- Generates horizontal and vertical sync, the video-on window, raw counters, active-area pixel coordinates, and line/frame start strobes.
- Adds a pixel clock-enable, configurable sync polarity, and a configurable output pipeline delay so that sync and vidon line up with downstream pixel-generation logic (paddle/ball renderer).
- Sits between the clock logic and the game renderer/VGA pins.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, hsync pulse width (pixels)
- H_BP, 160, horizontal back porch (pixels)
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync pulse width (lines)
- V_BP, 29, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- CW, 11, counter/coordinate width; must satisfy 2^CW >= max(H_TOTAL, V_TOTAL)
- LAT, 1, output pipeline stages; LAT >= 1

Ports:
- clk  in  1  system clock
- clr  in  1  reset, synchronous, active-high
- pix_en  in  1  pixel strobe; counters and pipeline advance only when high
- hsync  out  1  horizontal sync, polarity set by HS_POL
- vsync  out  1  vertical sync, polarity set by VS_POL
- vidon  out  1  high inside the active area
- hc  out  CW  horizontal counter, delayed by LAT
- vc  out  CW  vertical counter, delayed by LAT
- px  out  CW  active-area x (0..H_ACTIVE-1); 0 outside the active area
- py  out  CW  active-area y (0..V_ACTIVE-1); 0 outside the active area
- line_start  out  1  one-clk strobe at hc==0
- frame_start  out  1  one-clk strobe at hc==0 && vc==0

Behaviour:
- Derived values: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (default 1344); V_TOTAL likewise (default 806).
- Line order from count 0: sync, back porch, active, front porch.
- Counters (stage 0), on clk when pix_en:
  - hch increments and wraps H_TOTAL-1 -> 0.
  - vch increments only on that wrap, and itself wraps V_TOTAL-1 -> 0.
  - When pix_en is low, the counters hold.
- Decode from the stage-0 counters:
  - hs_act = hch < H_SYNC
  - vs_act = vch < V_SYNC
  - act = hch in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and vch in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1]
  - px = hch-(H_SYNC+H_BP) when act, else 0; py likewise
  - ls = hch==0
  - fs = ls && vch==0
- Output pipeline:
  - LAT register stages; every stage loads only on pix_en.
  - Outputs are the final stage: hsync = hs_act ? HS_POL : ~HS_POL; vsync likewise with VS_POL.
  - Output state at any time is the decode of the counter value from LAT pix_en strobes earlier.
- Strobes:
  - line_start and frame_start are high only in the clk cycle following a pix_en that loaded a true value into the final stage.
  - In all other cycles they are forced low, even when pix_en is low and the stage holds.
- Reset (clr=1 at a clk edge, any time, including mid-frame):
  - Counters go to 0.
  - All pipeline stages go to idle: hsync=~HS_POL, vsync=~VS_POL, vidon=0, hc=vc=px=py=0, strobes 0.
  - clr overrides pix_en.
- After reset release:
  - The first pix_en moves the counters 0 -> 1 and loads stage 1 with the decode of count 0.
  - With LAT=1, the next clk shows hsync active, vsync active, line_start=1 and frame_start=1.
- Boundary at the last pixel of the frame (hch=H_TOTAL-1, vch=V_TOTAL-1): one pix_en wraps both counters to 0 together.
- No combinational path from any input to any output; all outputs are registered.
- px/py are never non-zero while vidon=0.

Test Plan:
- Reset: hold clr 3 cycles, pix_en=1 -> hsync=vsync=1, vidon=0, hc=vc=px=py=0, strobes 0; first post-reset pix_en followed by frame_start=1 for one cycle (LAT=1).
- Line timing, defaults, pix_en=1 -> hsync low for exactly 136 clks per 1344-clk line; vidon high for exactly 1024 consecutive clks starting at hc=296; px runs 0..1023 in step with vidon.
- Frame timing -> vsync low for 6 lines (8064 clks); frame_start period exactly 1,083,264 clks; 768 vidon lines per frame, first at vc=35; hc=1343, vc=805 -> next hc=0, vc=0.
- pix_en toggling every other clk -> all periods double; frame_start still exactly one clk wide; outputs hold while pix_en=0.
- LAT=3 vs LAT=1 run in parallel with identical stimulus -> every output of LAT=3 equals LAT=1 delayed by 2 pix_en strobes.
- Assert clr mid-active-area (vc=400, hc=700) -> next clk all outputs at reset values; HS_POL=1 build -> hsync high only during sync.
